// File: rtl/fixed_accumulator_arbiter_pkg.sv
// Shared types for the accumulator arbiter: the arbitration FSM state encoding.
package fixed_accumulator_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DRAIN
   } state_t;

endpackage

// File: rtl/fixed_accumulator_arbiter_if.sv
// Requester, accumulator and result handshakes of the accumulator arbiter.
interface fixed_accumulator_arbiter_if #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned IN_DEPTH  = 4,
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH,
   parameter int unsigned ID_WIDTH  = $clog2(N_REQ)
);

   logic [N_REQ*IN_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [IN_WIDTH-1:0]       acc_data;
   logic                      acc_valid;
   logic                      acc_ready;
   logic [OUT_WIDTH-1:0]      acc_result;
   logic                      acc_result_valid;
   logic                      acc_result_ready;
   logic [OUT_WIDTH-1:0]      data_out;
   logic [ID_WIDTH-1:0]       data_out_id;
   logic                      data_out_valid;
   logic                      data_out_ready;

   // Environment side: producers, accumulator and result consumer.
   modport master (
      output req_data, req_valid, acc_ready, acc_result, acc_result_valid, data_out_ready,
      input  req_ready, acc_data, acc_valid, acc_result_ready, data_out, data_out_id,
             data_out_valid
   );

   // Arbiter side.
   modport slave (
      input  req_data, req_valid, acc_ready, acc_result, acc_result_valid, data_out_ready,
      output req_ready, acc_data, acc_valid, acc_result_ready, data_out, data_out_id,
             data_out_valid
   );

endinterface

// File: rtl/fixed_accumulator.sv
// Burst accumulator: sums IN_DEPTH sign-extended beats, presents the sum until
// it is taken, then clears for the next burst.
module fixed_accumulator #(
   parameter int unsigned IN_DEPTH  = 4,
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 data_out_valid,
   input  logic                 data_out_ready
);

   localparam int unsigned CNT_W = $clog2(IN_DEPTH + 1);

   logic [CNT_W-1:0]     cnt_q;
   logic [OUT_WIDTH-1:0] sum_q;
   logic                 full;

   assign full           = (cnt_q == CNT_W'(IN_DEPTH));
   assign data_in_ready  = !full;
   assign data_out_valid = full;
   assign data_out       = sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sum_q <= '0;
      end else if (data_in_valid && data_in_ready) begin
         cnt_q <= cnt_q + CNT_W'(1);
         sum_q <= sum_q + OUT_WIDTH'(signed'(data_in));
      end else if (full && data_out_ready) begin
         cnt_q <= '0;
         sum_q <= '0;
      end
   end

endmodule

// File: rtl/fixed_accumulator_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping
// at N_REQ so indices >= N_REQ are never produced.
module rr_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]    req_i,
   input  logic [ID_WIDTH-1:0] last_grant_i,
   output logic [ID_WIDTH-1:0] grant_o,
   output logic                any_o
);

   always_comb begin
      int unsigned idx;
      grant_o = '0;
      any_o   = 1'b0;
      idx     = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = (32'(last_grant_i) + i) % N_REQ;
         if (!any_o && req_i[idx]) begin
            any_o   = 1'b1;
            grant_o = ID_WIDTH'(idx);
         end
      end
   end

endmodule

// File: rtl/fixed_accumulator_arbiter.sv
// Shares one burst accumulator between N_REQ requesters: grants a whole burst
// round-robin, then passes the tagged sum through to the result port.
module fixed_accumulator_arbiter
   import fixed_accumulator_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned IN_DEPTH  = 4,
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH,
   parameter int unsigned ID_WIDTH  = $clog2(N_REQ)
) (
   input logic                      clk,
   input logic                      rst,
   fixed_accumulator_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(IN_DEPTH + 1);

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d;
   logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

   logic [ID_WIDTH-1:0]  pick;
   logic                 pick_any;
   logic [IN_WIDTH-1:0]  sel_data;
   logic                 sel_valid;

   logic [N_REQ-1:0]     req_ready_o;
   logic [IN_WIDTH-1:0]  acc_data_o;
   logic                 acc_valid_o;
   logic                 acc_result_ready_o;
   logic [OUT_WIDTH-1:0] data_out_o;
   logic [ID_WIDTH-1:0]  data_out_id_o;
   logic                 data_out_valid_o;

   rr_arbiter #(
      .N_REQ   (N_REQ),
      .ID_WIDTH(ID_WIDTH)
   ) u_rr (
      .req_i       (bus.req_valid),
      .last_grant_i(last_grant_q),
      .grant_o     (pick),
      .any_o       (pick_any)
   );

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (ID_WIDTH'(i) == grant_q) begin
            sel_data  = bus.req_data[i*IN_WIDTH +: IN_WIDTH];
            sel_valid = bus.req_valid[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_WIDTH'(N_REQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      last_grant_d       = last_grant_q;
      beat_cnt_d         = beat_cnt_q;
      req_ready_o        = '0;
      acc_data_o         = '0;
      acc_valid_o        = 1'b0;
      acc_result_ready_o = 1'b0;
      data_out_o         = '0;
      data_out_id_o      = '0;
      data_out_valid_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d    = pick;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            acc_data_o  = sel_data;
            acc_valid_o = sel_valid;
            for (int unsigned i = 0; i < N_REQ; i++) begin
               req_ready_o[i] = (ID_WIDTH'(i) == grant_q) && bus.acc_ready;
            end
            if (sel_valid && bus.acc_ready) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == CNT_W'(IN_DEPTH - 1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // acc_valid stays low here so the accumulator clears on this handshake.
            data_out_o         = bus.acc_result;
            data_out_valid_o   = bus.acc_result_valid;
            acc_result_ready_o = bus.data_out_ready;
            data_out_id_o      = grant_q;
            if (bus.acc_result_valid && bus.data_out_ready) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready        = req_ready_o;
   assign bus.acc_data         = acc_data_o;
   assign bus.acc_valid        = acc_valid_o;
   assign bus.acc_result_ready = acc_result_ready_o;
   assign bus.data_out         = data_out_o;
   assign bus.data_out_id      = data_out_id_o;
   assign bus.data_out_valid   = data_out_valid_o;

endmodule
